my_nor: RTL and testbench

MY_NOR -- requirements
Module: my_nor

---
 rtl/my_nor_pkg.sv | 14 +
 rtl/my_nor_if.sv | 24 ++
 rtl/my_nor_stats.sv | 43 ++++
 rtl/my_nor.sv | 66 ++++++
 tb/tb_my_nor.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/my_nor_pkg.sv
// Shared constants and helpers for the my_nor block.
package my_nor_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned w);
        logic [31:0] max_val;
        max_val = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/my_nor_if.sv
// Signal bundle for the my_nor operand/result path; master drives operands, slave produces results.
interface my_nor_if #(
    parameter int WIDTH = my_nor_pkg::DEF_WIDTH,
    parameter int CNT_W = my_nor_pkg::DEF_CNT_W
);
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;
    logic             in_valid;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] op_q;
    logic             out_valid;
    logic [CNT_W-1:0] eval_cnt;
    logic [CNT_W-1:0] true_cnt;

    modport master (
        output input1, input2, in_valid,
        input  op, op_q, out_valid, eval_cnt, true_cnt
    );

    modport slave (
        input  input1, input2, in_valid,
        output op, op_q, out_valid, eval_cnt, true_cnt
    );
endinterface

// File: rtl/my_nor_stats.sv
// Saturating sample counters for my_nor: all accepted samples and those with an all-ones result.
module my_nor_stats
    import my_nor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic             sample_true,
    output logic [CNT_W-1:0] eval_cnt,
    output logic [CNT_W-1:0] true_cnt
);

    logic [CNT_W-1:0] eval_cnt_q, eval_cnt_d;
    logic [CNT_W-1:0] true_cnt_q, true_cnt_d;

    // Both counters share one ceiling, so true_cnt can never overtake eval_cnt.
    always_comb begin
        eval_cnt_d = eval_cnt_q;
        true_cnt_d = true_cnt_q;
        if (sample_valid) begin
            eval_cnt_d = CNT_W'(sat_inc(32'(eval_cnt_q), CNT_W));
            if (sample_true) begin
                true_cnt_d = CNT_W'(sat_inc(32'(true_cnt_q), CNT_W));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eval_cnt_q <= '0;
            true_cnt_q <= '0;
        end else begin
            eval_cnt_q <= eval_cnt_d;
            true_cnt_q <= true_cnt_d;
        end
    end

    assign eval_cnt = eval_cnt_q;
    assign true_cnt = true_cnt_q;

endmodule

// File: rtl/my_nor.sv
// Bitwise NOR with a registered result and optional sample statistics.
// Define MY_NOR_STATS_EN to build the eval_cnt/true_cnt counters; otherwise they read as 0.
module my_nor
    import my_nor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] op,
    output logic [WIDTH-1:0] op_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] eval_cnt,
    output logic [CNT_W-1:0] true_cnt
);

    logic [WIDTH-1:0] op_d;
    logic             out_valid_q, out_valid_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_nor
        assign op[gi] = ~(input1[gi] | input2[gi]);
    end

    always_comb begin
        op_d        = op_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            op_d        = op;
            out_valid_d = 1'b1;
        end
    end

    // Reset value is the NOR of two zero operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q        <= '1;
            out_valid_q <= 1'b0;
        end else begin
            op_q        <= op_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

`ifdef MY_NOR_STATS_EN
    my_nor_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(in_valid),
        .sample_true (&op),
        .eval_cnt    (eval_cnt),
        .true_cnt    (true_cnt)
    );
`else
    assign eval_cnt = '0;
    assign true_cnt = '0;
`endif

endmodule

// File: tb/tb_my_nor.sv
// Self-checking bench for my_nor: truth table, directed reset/latency/saturation sequences, random traffic.
module tb_my_nor;

`ifdef MY_NOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam int W2 = 4;
    localparam int C2 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    my_nor_if #(.WIDTH(1), .CNT_W(16)) bus ();

    logic [W2-1:0] a2, b2, op2, opq2;
    logic          ov2;
    logic [C2-1:0] ev2, tr2;

    my_nor #(.WIDTH(1), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .input1   (bus.input1),
        .input2   (bus.input2),
        .in_valid (bus.in_valid),
        .op       (bus.op),
        .op_q     (bus.op_q),
        .out_valid(bus.out_valid),
        .eval_cnt (bus.eval_cnt),
        .true_cnt (bus.true_cnt)
    );

    my_nor #(.WIDTH(W2), .CNT_W(C2)) dut_w (
        .clk      (clk),
        .rst      (rst),
        .input1   (a2),
        .input2   (b2),
        .in_valid (bus.in_valid),
        .op       (op2),
        .op_q     (opq2),
        .out_valid(ov2),
        .eval_cnt (ev2),
        .true_cnt (tr2)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: [0] is the 1-bit/16-bit-counter instance, [1] the 4-bit/2-bit one.
    int m_opq[2], m_ov[2], m_ev[2], m_tr[2];
    int m_width[2] = '{1, W2};
    int m_cmax[2]  = '{65535, 3};

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input int idx, input int a, input int b, input bit v, input bit r);
        int all_ones, res;
        all_ones = (1 << m_width[idx]) - 1;
        res = all_ones - ((a | b) & all_ones);
        if (r) begin
            m_opq[idx] = all_ones;
            m_ov[idx]  = 0;
            m_ev[idx]  = 0;
            m_tr[idx]  = 0;
        end else if (v) begin
            m_opq[idx] = res;
            m_ov[idx]  = 1;
            if (STATS) begin
                if (m_ev[idx] < m_cmax[idx]) m_ev[idx]++;
                if (res == all_ones && m_tr[idx] < m_cmax[idx]) m_tr[idx]++;
            end
        end else begin
            m_ov[idx] = 0;
        end
    endtask

    // One clock cycle: drive, check combinational op, advance model, check registered outputs.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic v, input logic r);
        bus.input1   = a[0];
        bus.input2   = b[0];
        a2           = a;
        b2           = b;
        bus.in_valid = v;
        rst          = r;
        #1;
        check("op_n1", int'(bus.op), (a[0] | b[0]) ? 0 : 1);
        check("op_n4", int'(op2), 15 - int'(a | b));
        model_step(0, int'(a[0]), int'(b[0]), v, r);
        model_step(1, int'(a), int'(b), v, r);
        @(posedge clk);
        #1;
        check("op_q_n1", int'(bus.op_q), m_opq[0]);
        check("out_valid_n1", int'(bus.out_valid), m_ov[0]);
        check("eval_cnt_n1", int'(bus.eval_cnt), m_ev[0]);
        check("true_cnt_n1", int'(bus.true_cnt), m_tr[0]);
        check("op_q_n4", int'(opq2), m_opq[1]);
        check("out_valid_n4", int'(ov2), m_ov[1]);
        check("eval_cnt_n4", int'(ev2), m_ev[1]);
        check("true_cnt_n4", int'(tr2), m_tr[1]);
        $display("[TB] a=%h b=%h v=%0d rst=%0d -> op_q=%0d/%h ov=%0d/%0d ev=%0d/%0d tr=%0d/%0d",
                 a, b, v, r, bus.op_q, opq2, bus.out_valid, ov2,
                 bus.eval_cnt, ev2, bus.true_cnt, tr2);
    endtask

    typedef struct {
        logic a;
        logic b;
        logic exp_op;
    } vec_t;

    vec_t tv[4];

    initial begin
        tv[0] = '{a: 1'b0, b: 1'b0, exp_op: 1'b1};
        tv[1] = '{a: 1'b1, b: 1'b0, exp_op: 1'b0};
        tv[2] = '{a: 1'b0, b: 1'b1, exp_op: 1'b0};
        tv[3] = '{a: 1'b1, b: 1'b1, exp_op: 1'b0};

        rst = 1'b0;
        bus.in_valid = 1'b0;
        a2 = '0;
        b2 = '0;

        // Combinational truth table.
        for (int i = 0; i < 4; i++) begin
            bus.input1 = tv[i].a;
            bus.input2 = tv[i].b;
            #1;
            check("truth_table", int'(bus.op), int'(tv[i].exp_op));
            $display("[TB] truth a=%0d b=%0d op=%0d", tv[i].a, tv[i].b, bus.op);
        end

        @(posedge clk);
        #1;

        // Reset pulse, with op still tracking the operands.
        apply(4'h1, 4'h0, 1'b0, 1'b1);
        check("reset_op_q", int'(bus.op_q), 1);
        check("reset_eval", int'(bus.eval_cnt), 0);

        // Back-to-back samples 00 then 11.
        apply(4'h0, 4'h0, 1'b1, 1'b0);
        check("seq_op_q_00", int'(bus.op_q), 1);
        apply(4'hF, 4'hF, 1'b1, 1'b0);
        check("seq_op_q_11", int'(bus.op_q), 0);
        check("seq_valid", int'(bus.out_valid), 1);
        check("seq_eval", int'(bus.eval_cnt), STATS ? 2 : 0);
        check("seq_true", int'(bus.true_cnt), STATS ? 1 : 0);

        // Idle cycles hold op_q and counters.
        for (int i = 0; i < 3; i++) apply(4'h0, 4'h0, 1'b0, 1'b0);
        check("idle_op_q", int'(bus.op_q), 0);
        check("idle_eval", int'(bus.eval_cnt), STATS ? 2 : 0);

        // Reset wins over a simultaneous sample.
        apply(4'h0, 4'h0, 1'b1, 1'b1);
        check("rst_prio_eval", int'(bus.eval_cnt), 0);

        // Saturation of the 2-bit counters.
        for (int i = 0; i < 5; i++) apply(4'h0, 4'h0, 1'b1, 1'b0);
        check("sat_eval", int'(ev2), STATS ? 3 : 0);
        check("sat_true", int'(tr2), STATS ? 3 : 0);

        // Mid-stream reset restarts counting.
        apply(4'h3, 4'h0, 1'b0, 1'b1);
        apply(4'h0, 4'h0, 1'b1, 1'b0);
        check("restart_eval", int'(ev2), STATS ? 1 : 0);

        // Random traffic against the model; operands biased toward zero for all-ones results.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] ra, rb;
            ra = 4'($urandom) & ((($urandom % 3) == 0) ? 4'h0 : 4'($urandom));
            rb = 4'($urandom) & ((($urandom % 3) == 0) ? 4'h0 : 4'($urandom));
            apply(ra, rb, 1'($urandom % 2), ($urandom % 25) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
